// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner.
// Walks an active-low column strobe, debounces a single-key press and its
// release, and reports the accepted key as a hex code with a one-cycle
// valid strobe. Multi-key chords are ignored.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,  // cycles per column step (>= 2)
  parameter int DEBOUNCE_CNT = 500000  // stable cycles for press/release (>= 2)
) (
  input  logic       Keypad_CLK,
  input  logic       Keypad_RST,
  input  logic [3:0] Row_IN,
  output logic [3:0] Col_OUT,
  output logic [3:0] Key_OUT,
  output logic       Key_VALID,
  output logic       Key_DOWN
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t            state_reg;
  logic [3:0]        row_meta_reg;
  logic [3:0]        row_sync_reg;
  logic [1:0]        col_reg;
  logic [1:0]        row_idx_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [DB_W-1:0]   db_cnt_reg;
  logic [3:0]        key_out_reg;
  logic              key_valid_reg;
  logic              key_down_reg;

  logic              tick;
  logic              row_single;
  logic [1:0]        row_idx_next;
  logic [3:0]        row_pat;

  // Hex code for a (row, col) position on the keypad face.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;  // '*'
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;  // '#'
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer; rows idle high, so reset to all-ones.
  always_ff @(posedge Keypad_CLK) begin
    if (Keypad_RST) begin
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
    end else begin
      row_meta_reg <= Row_IN;
      row_sync_reg <= row_meta_reg;
    end
  end

  // Identify a synchronized row pattern with exactly one row pulled low.
  always_comb begin
    row_single   = 1'b1;
    row_idx_next = 2'd0;
    case (row_sync_reg)
      4'b1110: row_idx_next = 2'd0;
      4'b1101: row_idx_next = 2'd1;
      4'b1011: row_idx_next = 2'd2;
      4'b0111: row_idx_next = 2'd3;
      default: row_single   = 1'b0;
    endcase
  end

  // Pattern the held key must keep showing while it is being debounced.
  assign row_pat = ~(4'b0001 << row_idx_reg);

  // Column step strobe; the divider only counts while scanning.
  assign tick = (state_reg == SCAN) && (div_cnt_reg == DIV_LAST);

  // Scan / debounce / report / release sequencer with registered outputs.
  always_ff @(posedge Keypad_CLK) begin
    if (Keypad_RST) begin
      state_reg     <= SCAN;
      col_reg       <= 2'd0;
      row_idx_reg   <= 2'd0;
      div_cnt_reg   <= '0;
      db_cnt_reg    <= '0;
      key_out_reg   <= 4'h0;
      key_valid_reg <= 1'b0;
      key_down_reg  <= 1'b0;
    end else begin
      key_valid_reg <= 1'b0;
      case (state_reg)
        SCAN: begin
          if (tick) begin
            div_cnt_reg <= '0;
            if (row_single) begin
              // Exactly one row low: hold this column and start debouncing.
              row_idx_reg <= row_idx_next;
              db_cnt_reg  <= '0;
              state_reg   <= DEBOUNCE;
            end else begin
              // Nothing pressed, or an ambiguous chord: keep scanning.
              col_reg <= col_reg + 2'd1;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (row_sync_reg == row_pat) begin
            if (db_cnt_reg == DB_LAST) begin
              state_reg     <= PRESSED;
              key_out_reg   <= key_code(row_idx_reg, col_reg);
              key_valid_reg <= 1'b1;
              key_down_reg  <= 1'b1;
            end else begin
              db_cnt_reg <= db_cnt_reg + 1'b1;
            end
          end else begin
            // Bounce or glitch: abandon this key and move on.
            state_reg  <= SCAN;
            db_cnt_reg <= '0;
            col_reg    <= col_reg + 2'd1;
          end
        end
        PRESSED: begin
          state_reg  <= RELEASE;
          db_cnt_reg <= '0;
        end
        RELEASE: begin
          if (row_sync_reg == 4'hF) begin
            if (db_cnt_reg == DB_LAST) begin
              state_reg    <= SCAN;
              db_cnt_reg   <= '0;
              key_down_reg <= 1'b0;
              col_reg      <= col_reg + 2'd1;
            end else begin
              db_cnt_reg <= db_cnt_reg + 1'b1;
            end
          end else begin
            // Any row still low restarts the release window.
            db_cnt_reg <= '0;
          end
        end
        default: state_reg <= SCAN;
      endcase
    end
  end

  // One-cold column drive: a bit is low only for the selected column.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign Col_OUT[gi] = (col_reg != 2'(gi));
    end
  endgenerate

  assign Key_OUT   = key_out_reg;
  assign Key_VALID = key_valid_reg;
  assign Key_DOWN  = key_down_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 keypad that
// pulls rows low from the column strobe.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_out;
  logic       key_valid;
  logic       key_down;
  logic [15:0] keys_down = '0;  // bit r*4+c set when key (r,c) is held

  int n_cmp = 0;
  int n_bad = 0;
  int valid_cycles = 0;
  logic [3:0] last_code = 4'h0;

  typedef struct {
    int         row;
    int         col;
    logic [3:0] code;
  } vec_t;

  vec_t vecs[15];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .Keypad_CLK (clk),
    .Keypad_RST (rst),
    .Row_IN     (row_in),
    .Col_OUT    (col_out),
    .Key_OUT    (key_out),
    .Key_VALID  (key_valid),
    .Key_DOWN   (key_down)
  );

  always #5 clk = ~clk;

  // Keypad model: a held key connects its row to its column strobe.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // Valid-strobe monitor: counts high cycles and remembers the reported code.
  always @(negedge clk) begin
    if (key_valid) begin
      valid_cycles <= valid_cycles + 1;
      last_code    <= key_out;
      $display("key_valid: code=%h at %0t", key_out, $time);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!key_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int lat;
    int consec;
    int waited;
    int cnt_bad;

    vecs[0]  = '{3, 1, 4'h0};
    vecs[1]  = '{0, 1, 4'h2};
    vecs[2]  = '{2, 1, 4'h8};
    vecs[3]  = '{0, 0, 4'h1};
    vecs[4]  = '{1, 0, 4'h4};
    vecs[5]  = '{0, 2, 4'h3};
    vecs[6]  = '{0, 3, 4'hA};
    vecs[7]  = '{1, 1, 4'h5};
    vecs[8]  = '{1, 2, 4'h6};
    vecs[9]  = '{1, 3, 4'hB};
    vecs[10] = '{2, 0, 4'h7};
    vecs[11] = '{2, 2, 4'h9};
    vecs[12] = '{2, 3, 4'hC};
    vecs[13] = '{3, 0, 4'hE};
    vecs[14] = '{3, 3, 4'hD};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col_out", col_out, 4'b1110);
    check("rst_key_out", key_out, 4'h0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_down", key_down, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_col_out", col_out, 4'b1110);
    check("post_rst_key_valid", key_valid, 1'b0);

    // Press '2', hold 100 cycles, release; exact release window
    base = valid_cycles;
    keys_down[0*4+1] = 1'b1;
    wait_valid(lat);
    check("k2_latency_in_bound", (lat >= 11 && lat <= 27), 1'b1);
    check("k2_key_out", key_out, 4'h2);
    repeat (100 - lat) @(negedge clk);
    check("k2_down_held", key_down, 1'b1);
    keys_down = '0;
    repeat (9) @(negedge clk);
    check("k2_down_before_8_clean", key_down, 1'b1);
    @(negedge clk);
    check("k2_down_after_8_clean", key_down, 1'b0);
    repeat (50) @(negedge clk);
    check("k2_pulse_cycles", valid_cycles - base, 1);
    check("k2_code", last_code, 4'h2);

    // Table: sequence 0,2,8,1,4 then rest of the key map
    for (int i = 0; i < 15; i++) begin
      base = valid_cycles;
      keys_down[vecs[i].row*4 + vecs[i].col] = 1'b1;
      repeat (60) @(negedge clk);
      check($sformatf("vec%0d_down", i), key_down, 1'b1);
      keys_down = '0;
      repeat (60) @(negedge clk);
      check($sformatf("vec%0d_pulses", i), valid_cycles - base, 1);
      check($sformatf("vec%0d_code", i), last_code, vecs[i].code);
      check($sformatf("vec%0d_key_out", i), key_out, vecs[i].code);
      check($sformatf("vec%0d_released", i), key_down, 1'b0);
    end

    // Bouncing '5' then stable
    base = valid_cycles;
    for (int t = 0; t < 10; t++) begin
      keys_down[1*4+1] = ~keys_down[1*4+1];
      repeat (3) @(negedge clk);
    end
    keys_down[1*4+1] = 1'b1;
    repeat (60) @(negedge clk);
    keys_down = '0;
    repeat (60) @(negedge clk);
    check("bounce5_pulses", valid_cycles - base, 1);
    check("bounce5_code", last_code, 4'h5);

    // '1' and '4' together: chord ignored
    base = valid_cycles;
    cnt_bad = 0;
    keys_down[0*4+0] = 1'b1;
    keys_down[1*4+0] = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (key_down) cnt_bad++;
    end
    keys_down = '0;
    repeat (20) @(negedge clk);
    check("chord_pulses", valid_cycles - base, 0);
    check("chord_key_out_kept", key_out, 4'h5);
    check("chord_down_cycles", cnt_bad, 0);

    // Reset while debouncing '9'
    keys_down[2*4+2] = 1'b1;
    consec = 0;
    waited = 0;
    while (consec < 5 && waited < 200) begin
      @(negedge clk);
      waited++;
      if (col_out == 4'b1011) consec++;
      else consec = 0;
    end
    check("k9_reached_debounce", consec, 5);
    base = valid_cycles;
    rst = 1'b1;
    keys_down = '0;
    @(negedge clk);
    check("k9_rst_col_out", col_out, 4'b1110);
    check("k9_rst_key_out", key_out, 4'h0);
    check("k9_rst_key_valid", key_valid, 1'b0);
    check("k9_rst_key_down", key_down, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("k9_post_col_out", col_out, 4'b1110);
    check("k9_post_key_valid", key_valid, 1'b0);
    repeat (3) @(negedge clk);
    check("k9_scan_resumes_col1", col_out, 4'b1101);
    repeat (20) @(negedge clk);
    check("k9_no_pulse", valid_cycles - base, 0);
    check("k9_key_out_stays", key_out, 4'h0);

    // Hold '#' for 500 cycles
    base = valid_cycles;
    keys_down[3*4+2] = 1'b1;
    wait_valid(lat);
    check("hash_latency_in_bound", (lat >= 11 && lat <= 27), 1'b1);
    check("hash_key_out", key_out, 4'hF);
    cnt_bad = 0;
    for (int t = 0; t < 500 - lat; t++) begin
      @(negedge clk);
      if (col_out != 4'b1011) cnt_bad++;
    end
    check("hash_col_held_violations", cnt_bad, 0);
    check("hash_down_held", key_down, 1'b1);
    keys_down = '0;
    repeat (40) @(negedge clk);
    check("hash_pulses", valid_cycles - base, 1);
    check("hash_code", last_code, 4'hF);
    check("hash_released", key_down, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles per column step (minimum 2).
REQ-002 Parameter DEBOUNCE_CNT, default 500000, consecutive stable cycles required for press or release (minimum 2).
REQ-003 Port Keypad_CLK  input  1  single system clock; all state on rising edge.
REQ-004 Port Keypad_RST  input  1  synchronous, active-high reset.
REQ-005 Port Row_IN  input  4  keypad rows, active-low, externally pulled up, asynchronous to Keypad_CLK.
REQ-006 Port Col_OUT  output  4  keypad column drive, one-hot active-low.
REQ-007 Port Key_OUT  output  4  hex code of last accepted key; feeds the combination-lock Key_IN.
REQ-008 Port Key_VALID  output  1  one-cycle pulse when Key_OUT is updated.
REQ-009 Port Key_DOWN  output  1  high while an accepted key is held.

Function
REQ-010 Row_IN SHALL pass through a 2-flop synchronizer (reset value 4'hF); all decisions SHALL use the synchronized value RowS.
REQ-011 A column index col (0..3) SHALL drive Col_OUT = ~(4'b0001 << col).
REQ-012 A divider SHALL assert tick once every SCAN_DIV cycles; it SHALL run only in state SCAN and clear on leaving SCAN.
REQ-013 The FSM SHALL have states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-014 SCAN, on tick: if RowS == 4'hF, col SHALL advance (3 wraps to 0).
REQ-015 SCAN, on tick: if exactly one RowS bit is low, row and col SHALL be latched, col held, and the FSM SHALL enter DEBOUNCE with debounce counter = 0.
REQ-016 SCAN, on tick: if two or more RowS bits are low, the press SHALL be ignored and col SHALL advance.
REQ-017 DEBOUNCE: counter SHALL increment each cycle RowS equals the latched pattern.
REQ-018 DEBOUNCE: any mismatch SHALL return the FSM to SCAN with col advanced and no output change.
REQ-019 DEBOUNCE: when the counter reaches DEBOUNCE_CNT-1 with a match, the FSM SHALL enter PRESSED.
REQ-020 PRESSED SHALL last exactly one cycle: Key_OUT loaded, Key_VALID = 1, then RELEASE with counter = 0.
REQ-021 Key map (row,col -> code): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E(*),0,F(#),D.
REQ-022 RELEASE: col SHALL stay held.
REQ-023 RELEASE: counter SHALL increment while RowS == 4'hF and clear to 0 when any bit is low.
REQ-024 RELEASE: at DEBOUNCE_CNT-1, the FSM SHALL return to SCAN with col advanced.
REQ-025 Key_DOWN SHALL be 1 in PRESSED and RELEASE, else 0.
REQ-026 Key_OUT SHALL hold its value between accepted keys; a repeated key SHALL produce a new Key_VALID pulse only after a full release.
REQ-027 Worst-case press-to-Key_VALID latency SHALL be 2 + 4*SCAN_DIV + DEBOUNCE_CNT + 1 cycles.
REQ-028 Counters SHALL be sized by $clog2 of their parameter and SHALL never wrap.

Reset
REQ-029 Keypad_RST high at a clock edge SHALL force state SCAN, col = 0, Col_OUT = 4'b1110, both counters 0, synchronizer 4'hF, Key_OUT = 4'h0, Key_VALID = 0, Key_DOWN = 0.
REQ-030 Reset SHALL take priority in every state, including mid-debounce and mid-release; no Key_VALID SHALL issue in the reset cycle or the first cycle after it.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8, behavioural keypad model driving Row_IN from Col_OUT)
REQ-031 Press '2' (r0,c1), hold 100 cycles, release -> exactly one Key_VALID, Key_OUT = 4'h2, Key_DOWN high until 8 clean released cycles.
REQ-032 Press sequence 0,2,8,1,4, each held 60 cycles with 60 idle -> five pulses with Key_OUT 0,2,8,1,4 in order.
REQ-033 Press '5' bouncing (toggling every 3 cycles for 30 cycles), then stable -> exactly one Key_VALID, 4'h5.
REQ-034 '1' and '4' pressed simultaneously (same column, two rows low) -> no Key_VALID; Key_OUT unchanged.
REQ-035 Keypad_RST for 1 cycle during DEBOUNCE of '9' -> all outputs at reset values, no pulse; scanning resumes at col 0.
REQ-036 Hold '#' for 500 cycles -> single pulse, Key_OUT = 4'hF, Col_OUT held at 4'b1011 throughout.
